puzzle_game_ctrl: RTL and testbench
===================================

PUZZLE_GAME_CTRL -- requirements
Module: puzzle_game_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 16: cycles a raw button must stay stable before its debounced level changes.
REQ-002 Parameter WIN_HOLD_CYCLES, 32: cycles spent in WIN before level advance.
REQ-003 Parameter MAX_LEVEL, 4: last level index; levels run 0..MAX_LEVEL.
REQ-004 Parameter MOVE_LIMIT, 63: moves allowed per level (MOVE_LIMIT_EN only).
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 btn_raw  in  8  raw pushbuttons, active-high, asynchronous to clk.
REQ-008 start  in  1  starts or restarts a game; level-sensitive, sampled in IDLE and DONE only.
REQ-009 nivel_concluido  in  1  win flag from matrix; registered there, valid 1 cycle after a toggle.
REQ-010 botoes  out  8  toggle strobes to matrix; at most one bit high, high for one cycle.
REQ-011 nivel  out  3  current level.
REQ-012 matrix_rst  out  1  one-cycle clear pulse to matrix.
REQ-013 win  out  1  high while in WIN.
REQ-014 game_done  out  1  high while in DONE.
REQ-015 moves  out  8  toggles issued in current level, saturating at 255.

Function
REQ-016 Each btn_raw bit SHALL pass a 2-flop synchronizer, then a debouncer updating the debounced level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-017 A debounced 0->1 edge SHALL set that bit's pending flag; pending flags SHALL set only in PLAY and SHALL all clear on any exit from PLAY/SETTLE to a non-play state.
REQ-018 In PLAY with any pending flag, the arbiter SHALL grant exactly one bit round-robin, starting at the index after the last grant (last grant = 7 after reset), drive that botoes bit for one cycle, clear its flag, increment moves, and go to SETTLE.
REQ-019 SETTLE SHALL last 2 cycles; on its final cycle, nivel_concluido=1 -> WIN, else -> PLAY.
REQ-020 FSM states: IDLE, CLEAR, PLAY, SETTLE, WIN, DONE.
REQ-021 IDLE: start=1 -> nivel=0, CLEAR.
REQ-022 CLEAR: matrix_rst=1 for exactly one cycle, moves=0 -> PLAY.
REQ-023 WIN: hold WIN_HOLD_CYCLES cycles; then nivel==MAX_LEVEL -> DONE, else nivel+1 -> CLEAR.
REQ-024 DONE: start=1 -> nivel=0, CLEAR.
REQ-025 Pending edges arriving in SETTLE SHALL be kept and served in later PLAY cycles; edges arriving outside PLAY/SETTLE SHALL be dropped.
REQ-026 botoes SHALL be 0 in every state except the PLAY grant cycle.

Reset
REQ-027 On rst: state=IDLE, nivel=0, botoes=0, matrix_rst=1 (held while rst high, 0 on first cycle after), win=0, game_done=0, moves=0, pending=0, debounced levels=0, last grant=7, all counters 0.
REQ-028 rst asserted mid-game SHALL abort immediately to the reset values; no strobe issued in the rst cycle.

Configuration
REQ-029 Macro PUZZLE_MOVE_LIMIT_EN: when defined, if moves reaches MOVE_LIMIT while in PLAY with nivel_concluido=0 after SETTLE, FSM SHALL go to CLEAR (same level restarted, pending cleared); when undefined, moves only counts and no restart occurs.

Structure
REQ-030 Shared package puzzle_pkg SHALL hold the FSM state encoding, NUM_BUTTONS=8, LEVEL_W=3 and default parameter constants.
REQ-031 One sub-module, btn_debounce (one instance per button: synchronizer, stable-counter, rising-edge pulse), SHALL be used; arbiter and FSM stay in the top.

Verification
REQ-032 rst released, start=1 -> one matrix_rst pulse, state PLAY, nivel=0, moves=0.
REQ-033 btn_raw[3] glitch of DEBOUNCE_CYCLES-1 cycles -> no botoes strobe; held DEBOUNCE_CYCLES+3 cycles -> exactly one botoes=8'h08 pulse, moves=1.
REQ-034 btn_raw[0] and btn_raw[5] debounce in same cycle, last grant=7 -> botoes=8'h01, then after SETTLE 8'h20; moves=2.
REQ-035 nivel_concluido=1 after a toggle at nivel=2 -> win high 32 cycles, then matrix_rst pulse, nivel=3, moves=0.
REQ-036 Win at nivel=4 -> game_done=1; start=1 -> nivel=0, matrix_rst pulse; rst mid-SETTLE -> all outputs at reset values.
REQ-037 With PUZZLE_MOVE_LIMIT_EN, MOVE_LIMIT=3, three non-winning toggles -> matrix_rst pulse, nivel unchanged, moves=0.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared definitions for the puzzle game controller: FSM encoding, sizes,
// default parameter values and the round-robin pick helper.
package puzzle_pkg;

  localparam int unsigned NUM_BUTTONS = 8;
  localparam int unsigned LEVEL_W     = 3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_WIN_HOLD_CYCLES = 32;
  localparam int unsigned DEF_MAX_LEVEL       = 4;
  localparam int unsigned DEF_MOVE_LIMIT      = 63;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StPlay,
    StSettle,
    StWin,
    StDone
  } state_t;

  // First requesting index after 'last', wrapping; caller guarantees req != 0.
  function automatic logic [2:0] rr_pick(input logic [NUM_BUTTONS-1:0] req,
                                         input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_BUTTONS; i++) begin
      idx = last + 3'(i);
      if (req[idx] && !found) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer, stable-sample counter and a
// rising-edge pulse issued in the cycle the debounced level goes high.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q, level_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  // Counter tracks consecutive samples that disagree with the debounced level.
  assign flip = (sync2_q != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise = flip && sync2_q;

  always_comb begin
    cnt_d = '0;
    if ((sync2_q != level_q) && !flip) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      if (flip) level_q <= sync2_q;
    end
  end

endmodule

// File: rtl/puzzle_game_ctrl.sv
// Puzzle game controller: debounced buttons, round-robin toggle arbiter and
// level FSM. Define PUZZLE_MOVE_LIMIT_EN to restart a level after MOVE_LIMIT moves.
module puzzle_game_ctrl
  import puzzle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned WIN_HOLD_CYCLES = DEF_WIN_HOLD_CYCLES,
  parameter int unsigned MAX_LEVEL       = DEF_MAX_LEVEL,
  parameter int unsigned MOVE_LIMIT      = DEF_MOVE_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  input  logic                   start,
  input  logic                   nivel_concluido,
  output logic [NUM_BUTTONS-1:0] botoes,
  output logic [LEVEL_W-1:0]     nivel,
  output logic                   matrix_rst,
  output logic                   win,
  output logic                   game_done,
  output logic [7:0]             moves
);

`ifdef PUZZLE_MOVE_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  localparam int unsigned CNT_W = $clog2(WIN_HOLD_CYCLES + 2);

  logic [NUM_BUTTONS-1:0] rise;
  state_t                 state_q, state_d;
  logic [LEVEL_W-1:0]     nivel_q, nivel_d;
  logic [7:0]             moves_q, moves_d;
  logic [NUM_BUTTONS-1:0] pending_q, pending_d;
  logic [2:0]             last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   matrix_rst_q;
  logic [NUM_BUTTONS-1:0] grant;
  logic [2:0]             gidx;
  logic                   limit_hit;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[g]),
      .rise   (rise[g])
    );
  end

  assign limit_hit = LimitEn && (moves_q >= 8'(MOVE_LIMIT));
  assign gidx      = rr_pick(pending_q, last_q);

  always_comb begin
    state_d   = state_q;
    nivel_d   = nivel_q;
    moves_d   = moves_q;
    last_d    = last_q;
    cnt_d     = '0;
    grant     = '0;
    pending_d = pending_q;
    if (state_q == StPlay || state_q == StSettle) pending_d = pending_q | rise;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          nivel_d = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        state_d = StPlay;
      end
      StPlay: begin
        if (|pending_q) begin
          grant[gidx] = 1'b1;
          // A fresh edge on the granted bit in this cycle is kept.
          pending_d   = (pending_q & ~grant) | rise;
          last_d      = gidx;
          if (moves_q != 8'hff) moves_d = moves_q + 8'd1;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == CNT_W'(1)) begin
          if (nivel_concluido) state_d = StWin;
          else if (limit_hit)  state_d = StClear;
          else                 state_d = StPlay;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWin: begin
        if (cnt_q == CNT_W'(WIN_HOLD_CYCLES - 1)) begin
          if (nivel_q == LEVEL_W'(MAX_LEVEL)) begin
            state_d = StDone;
          end else begin
            nivel_d = nivel_q + LEVEL_W'(1);
            state_d = StClear;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StClear) moves_d = '0;
    if (state_d != StPlay && state_d != StSettle) pending_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      nivel_q      <= '0;
      moves_q      <= '0;
      pending_q    <= '0;
      last_q       <= 3'd7;
      cnt_q        <= '0;
      matrix_rst_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      nivel_q      <= nivel_d;
      moves_q      <= moves_d;
      pending_q    <= pending_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      matrix_rst_q <= (state_d == StClear);
    end
  end

  assign botoes     = grant;
  assign nivel      = nivel_q;
  assign moves      = moves_q;
  assign matrix_rst = matrix_rst_q;
  assign win        = (state_q == StWin);
  assign game_done  = (state_q == StDone);

endmodule

// File: tb/tb_puzzle_game_ctrl.sv
// Directed self-checking bench for puzzle_game_ctrl; inputs driven and outputs
// sampled on the falling clock edge.
module tb_puzzle_game_ctrl;

`ifdef PUZZLE_MOVE_LIMIT_EN
  localparam int unsigned TB_MOVE_LIMIT = 3;
`else
  localparam int unsigned TB_MOVE_LIMIT = 63;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] btn_raw = '0;
  logic       start = 1'b0;
  logic       nivel_concluido = 1'b0;
  logic [7:0] botoes;
  logic [2:0] nivel;
  logic       matrix_rst;
  logic       win;
  logic       game_done;
  logic [7:0] moves;

  int checks = 0;
  int errors = 0;

  puzzle_game_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .WIN_HOLD_CYCLES(32),
    .MAX_LEVEL      (4),
    .MOVE_LIMIT     (TB_MOVE_LIMIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_raw        (btn_raw),
    .start          (start),
    .nivel_concluido(nivel_concluido),
    .botoes         (botoes),
    .nivel          (nivel),
    .matrix_rst     (matrix_rst),
    .win            (win),
    .game_done      (game_done),
    .moves          (moves)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset_start();
    rst = 1'b1;
    btn_raw = '0;
    nivel_concluido = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // Hold mask until the first strobe (bounded), then release; returns the strobe.
  task automatic press(input logic [7:0] mask, output logic [7:0] got);
    got = '0;
    btn_raw = mask;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (botoes != 0) begin
        got = botoes;
        break;
      end
    end
    btn_raw = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({botoes, nivel, matrix_rst, win, game_done, moves} !== {8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: botoes=%h nivel=%0d mrst=%b win=%b done=%b moves=%0d, required 00 0 1 0 0 0",
               botoes, nivel, matrix_rst, win, game_done, moves);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (matrix_rst !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_mrst: got %b required 0", matrix_rst);
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({matrix_rst, nivel, moves} !== {1'b1, 3'd0, 8'd0}) begin
      errors++;
      $display("FAIL start_clear: mrst=%b nivel=%0d moves=%0d, required 1 0 0", matrix_rst, nivel, moves);
    end
    @(negedge clk);
    checks++;
    if ({matrix_rst, botoes} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL start_pulse_width: mrst=%b botoes=%h, required 0 00", matrix_rst, botoes);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] seen [4];
    int         ns = 0;
    btn_raw = 8'h21;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 25) btn_raw = '0;
      if (botoes != 0 && ns < 4) begin
        seen[ns] = botoes;
        ns++;
      end
    end
    checks++;
    if (ns !== 2) begin
      errors++;
      $display("FAIL rr_count: got %0d strobes required 2", ns);
    end else begin
      checks++;
      if ({seen[0], seen[1]} !== {8'h01, 8'h20}) begin
        errors++;
        $display("FAIL rr_order: got %h then %h, required 01 then 20", seen[0], seen[1]);
      end
    end
    checks++;
    if (moves !== 8'd2) begin
      errors++;
      $display("FAIL rr_moves: got %0d required 2", moves);
    end
  endtask

  task automatic test_glitch();
    int         ns = 0;
    logic [7:0] val = '0;
    do_reset_start();
    btn_raw = 8'h08;
    repeat (15) @(negedge clk);
    btn_raw = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (botoes != 0) ns++;
    end
    checks++;
    if (ns !== 0) begin
      errors++;
      $display("FAIL glitch_filtered: got %0d strobes required 0", ns);
    end
    btn_raw = 8'h08;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 18) btn_raw = '0;
      if (botoes != 0) begin
        ns++;
        val = botoes;
      end
    end
    checks++;
    if ({ns[7:0], val, moves} !== {8'd1, 8'h08, 8'd1}) begin
      errors++;
      $display("FAIL debounce_hold: strobes=%0d botoes=%h moves=%0d, required 1 08 1", ns, val, moves);
    end
  endtask

  task automatic test_win(input logic [7:0] mask, input logic [2:0] exp_nivel, input bit exp_done);
    logic [7:0] got;
    int         wc = 0;
    press(mask, got);
    checks++;
    if (got !== mask) begin
      errors++;
      $display("FAIL win_toggle: got %h required %h", got, mask);
    end
    nivel_concluido = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (win) break;
    end
    while (win && wc < 100) begin
      wc++;
      @(negedge clk);
    end
    nivel_concluido = 1'b0;
    checks++;
    if (wc !== 32) begin
      errors++;
      $display("FAIL win_hold: got %0d cycles required 32", wc);
    end
    if (exp_done) begin
      checks++;
      if ({game_done, matrix_rst, nivel} !== {1'b1, 1'b0, 3'd4}) begin
        errors++;
        $display("FAIL game_done: done=%b mrst=%b nivel=%0d, required 1 0 4", game_done, matrix_rst, nivel);
      end
    end else begin
      checks++;
      if ({matrix_rst, nivel, moves} !== {1'b1, exp_nivel, 8'd0}) begin
        errors++;
        $display("FAIL level_advance: mrst=%b nivel=%0d moves=%0d, required 1 %0d 0",
                 matrix_rst, nivel, moves, exp_nivel);
      end
      @(negedge clk);
      checks++;
      if (matrix_rst !== 1'b0) begin
        errors++;
        $display("FAIL level_mrst_width: got %b required 0", matrix_rst);
      end
    end
  endtask

  task automatic test_done_restart();
    int ns = 0;
    btn_raw = 8'h02;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 25) btn_raw = '0;
      if (botoes != 0) ns++;
    end
    checks++;
    if ({ns[7:0], game_done} !== {8'd0, 1'b1}) begin
      errors++;
      $display("FAIL done_drop: strobes=%0d done=%b, required 0 1", ns, game_done);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({matrix_rst, nivel, game_done} !== {1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL done_restart: mrst=%b nivel=%0d done=%b, required 1 0 0", matrix_rst, nivel, game_done);
    end
  endtask

  task automatic test_rst_mid_settle();
    logic [7:0] got;
    int         ns = 0;
    repeat (5) @(negedge clk);
    press(8'h04, got);
    @(negedge clk);
    checks++;
    if ({got, moves} !== {8'h04, 8'd1}) begin
      errors++;
      $display("FAIL pre_rst_toggle: botoes=%h moves=%0d, required 04 1", got, moves);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({botoes, nivel, matrix_rst, win, game_done, moves} !== {8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rst_mid_settle: botoes=%h nivel=%0d mrst=%b win=%b done=%b moves=%0d, required 00 0 1 0 0 0",
               botoes, nivel, matrix_rst, win, game_done, moves);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (botoes != 0 || matrix_rst) ns++;
    end
    checks++;
    if (ns !== 0) begin
      errors++;
      $display("FAIL post_rst_idle: got %0d active cycles required 0", ns);
    end
  endtask

  task automatic test_move_limit();
    logic [7:0] got;
    bit         saw = 1'b0;
    logic [2:0] lvl = 3'd7;
    logic [7:0] mv = 8'hff;
    do_reset_start();
    for (int k = 0; k < 3; k++) begin
      press(8'h01 << k, got);
      checks++;
      if (got !== (8'h01 << k)) begin
        errors++;
        $display("FAIL limit_toggle_%0d: got %h required %h", k, got, 8'h01 << k);
      end
      if (k < 2) repeat (25) @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (matrix_rst && !saw) begin
        saw = 1'b1;
        lvl = nivel;
        mv  = moves;
      end
    end
`ifdef PUZZLE_MOVE_LIMIT_EN
    checks++;
    if ({saw, lvl, mv} !== {1'b1, 3'd0, 8'd0}) begin
      errors++;
      $display("FAIL move_limit_restart: mrst_seen=%b nivel=%0d moves=%0d, required 1 0 0", saw, lvl, mv);
    end
`else
    checks++;
    if ({saw, moves} !== {1'b0, 8'd3}) begin
      errors++;
      $display("FAIL move_count_only: mrst_seen=%b moves=%0d, required 0 3", saw, moves);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_start();
    test_round_robin();
    test_glitch();
    test_win(8'h02, 3'd1, 1'b0);
    test_win(8'h04, 3'd2, 1'b0);
    test_win(8'h10, 3'd3, 1'b0);
    test_win(8'h40, 3'd4, 1'b0);
    test_win(8'h80, 3'd4, 1'b1);
    test_done_restart();
    test_rst_mid_settle();
    test_move_limit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
